instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 76 +++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes decoder control bundles into RV32I words, buffered in a 4-entry FIFO.
// Optional error counter enabled by defining INSTR_ENCODER_ERRCNT_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  ctrl,
    input  logic [2:0]  F,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    input  logic        err_clr,
    output logic [7:0]  err_cnt
);
    logic        r_t, i_t, s_t, j_t, legal, push, pop, bad;
    logic [31:0] word;
    logic [31:0] mem [4];
    logic [1:0]  wp, rp;
    logic [2:0]  count;

    always_comb begin
        r_t   = (ctrl == 5'b00100 && F == 3'b000) ||
                (ctrl == 5'b00110 && (F == 3'b010 || F == 3'b111 || F == 3'b101));
        i_t   = ctrl == 5'b01100 && (F == 3'b000 || F == 3'b010 || F == 3'b111);
        s_t   = ctrl == 5'b11000 && F == 3'b010;
        j_t   = ctrl == 5'b01101 && F == 3'b000;
        legal = r_t || i_t || s_t || j_t;
        word  = r_t ? {7'b0, rs2, rs1, F, rd, 7'b0110011} :
                i_t ? {imm, rs1, F, rd, 7'b0010011} :
                s_t ? {imm[11:5], rs2, rs1, F, imm[4:0], 7'b0100011} :
                j_t ? {imm, rs1, F, rd, 7'b1100111} : 32'h0;
    end

    assign in_ready  = count != 3'd4;
    assign out_valid = count != 3'd0;
    assign instr     = out_valid ? mem[rp] : 32'h0;
    assign push      = in_valid && in_ready && legal;
    assign bad       = in_valid && in_ready && !legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk)
        if (push) mem[wp] <= word;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 2'd1;
            if (pop) rp <= rp + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) err <= 1'b0;
        else if (err_clr) err <= 1'b0;
        else if (bad) err <= 1'b1;

`ifdef INSTR_ENCODER_ERRCNT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (err_clr) cnt <= '0;
        else if (bad && cnt != 8'hff) cnt <= cnt + 8'd1;
    assign err_cnt = cnt;
`else
    assign err_cnt = 8'h0;
`endif
endmodule
